// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg: shared definitions for the LIFO stack controller.
//   state_t  - controller FSM encoding (ST_IDLE accepts ops, ST_RD waits on RAM q)
//   POP_LAT  - cycles from pop acceptance to the pop_valid pulse
package stack_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RD   = 1'b1
  } state_t;

  localparam int POP_LAT = 2;

endpackage

// File: rtl/stack_ctrl.sv
// stack_ctrl: LIFO controller in front of a single-port synchronous-read stack
// RAM. Push/pop requests from the client become one RAM access per cycle.
//
// Optional build macro: STACK_CTRL_ERR_EN adds a sticky 'err' output that
// records overflow/underflow attempts.
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   push_req/push_data   - push request and word; accepted when push_ready=1
//   push_ready           - idle and not full
//   pop_req              - pop request; accepted when pop_ready=1
//   pop_ready            - idle and not empty
//   pop_data/pop_valid   - popped word, valid during the one-cycle pulse
//   full/empty/count     - occupancy status (count == stack pointer)
//   ram_write_req/ram_addr/ram_data/ram_q - RAM access port
//   err                  - sticky overflow/underflow flag (STACK_CTRL_ERR_EN)
//   dbg_state            - current FSM state
//
// Handshake: a request is taken in the cycle where req=1 and ready=1 on the
// same clock edge; a request seen while ready=0 is dropped with no side effect
// and the client must keep req high until it is accepted. When both push and
// pop are acceptable in the same cycle, the pop is taken and the push waits.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int STACK_WIDTH     = 8,
  parameter int STACK_DEPTH_LOG = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_req,
  input  logic [STACK_WIDTH-1:0]     push_data,
  output logic                       push_ready,
  input  logic                       pop_req,
  output logic                       pop_ready,
  output logic [STACK_WIDTH-1:0]     pop_data,
  output logic                       pop_valid,
  output logic                       full,
  output logic                       empty,
  output logic [STACK_DEPTH_LOG:0]   count,
  output logic                       ram_write_req,
  output logic [STACK_DEPTH_LOG-1:0] ram_addr,
  output logic [STACK_WIDTH-1:0]     ram_data,
  input  logic [STACK_WIDTH-1:0]     ram_q,
`ifdef STACK_CTRL_ERR_EN
  output logic                       err,
`endif
  output state_t                     dbg_state
);

  localparam logic [STACK_DEPTH_LOG:0] DEPTH_W = {1'b1, {STACK_DEPTH_LOG{1'b0}}};

  state_t                     state_q, state_d;
  logic [STACK_DEPTH_LOG:0]   sp_q;
  logic [STACK_DEPTH_LOG-1:0] rd_addr;
  logic [STACK_DEPTH_LOG-1:0] addr_q;
  logic [STACK_WIDTH-1:0]     data_q;
  logic [STACK_WIDTH-1:0]     pop_data_q;
  // pop_sr[0] marks the RD cycle (ram_q valid), pop_sr[POP_LAT-1] is pop_valid.
  logic [POP_LAT-1:0]         pop_sr;
  logic                       idle;
  logic                       push_acc;
  logic                       pop_acc;

  assign idle       = (state_q == ST_IDLE);
  assign count      = sp_q;
  assign full       = (sp_q == DEPTH_W);
  assign empty      = (sp_q == '0);
  assign push_ready = idle & ~full;
  assign pop_ready  = idle & ~empty;

  // Gated by rst so nothing reaches the RAM during a reset cycle.
  assign pop_acc  = pop_req & pop_ready & ~rst;
  assign push_acc = push_req & push_ready & ~pop_acc & ~rst;

  // At full, sp = 2**LOG; its low bits are 0 and wrap to the top address.
  assign rd_addr = sp_q[STACK_DEPTH_LOG-1:0] - STACK_DEPTH_LOG'(1);

  // Address/data are driven combinationally in the accepting cycle and hold
  // their last value otherwise (including the RD cycle of a pop).
  assign ram_write_req = push_acc;
  assign ram_addr      = push_acc ? sp_q[STACK_DEPTH_LOG-1:0] :
                         pop_acc  ? rd_addr : addr_q;
  assign ram_data      = push_acc ? push_data : data_q;

  assign pop_valid = pop_sr[POP_LAT-1];
  assign pop_data  = pop_data_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pop_acc) state_d = ST_RD;
      ST_RD:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sp_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      pop_data_q <= '0;
      pop_sr     <= '0;
    end else begin
      state_q <= state_d;
      pop_sr  <= {pop_sr[POP_LAT-2:0], pop_acc};
      if (push_acc) begin
        sp_q   <= sp_q + (STACK_DEPTH_LOG+1)'(1);
        addr_q <= sp_q[STACK_DEPTH_LOG-1:0];
        data_q <= push_data;
      end else if (pop_acc) begin
        sp_q   <= sp_q - (STACK_DEPTH_LOG+1)'(1);
        addr_q <= rd_addr;
      end
      if (pop_sr[0]) pop_data_q <= ram_q;
    end
  end

`ifdef STACK_CTRL_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (idle & ((push_req & full) | (pop_req & empty))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule
